// File: rtl/flash_prog_seq.sv
// flash_prog_seq: one erase/program/verify transaction per request, issuing
// single commands to a byte-level SPI engine and checksumming the page.
module flash_prog_seq #(
  parameter int          ADDR_W     = 24,
  parameter int          LEN_W      = 9,
  parameter bit          ERASE_MODE = 1'b0,
  parameter logic [15:0] POLL_MAX   = 16'd50000,
  parameter bit          VERIFY_EN  = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              op_start,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [LEN_W-1:0]  op_len,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic              spi_start,
  output logic [7:0]        spi_cmd,
  output logic [ADDR_W-1:0] spi_addr,
  output logic [LEN_W-1:0]  spi_len,
  input  logic              spi_done,
  input  logic              w_data_req,
  input  logic [7:0]        src_data,
  output logic              src_rd,
  output logic [7:0]        spi_wdata,
  input  logic [7:0]        spi_rdata,
  input  logic              spi_rvalid
);
  typedef enum logic [3:0] {IDLE, WREN1, ERASE, POLL1, WREN2, PROG, POLL2, READ, CHECK, FIN} state_t;
  state_t state, nxt;
  logic pend, wip_q, wip, is_poll, in_cmd, adv, again, timeout;
  logic [ADDR_W-1:0] addr_q, n_addr;
  logic [LEN_W-1:0] len_q, n_len;
  logic [15:0] cnt;
  logic [16:0] cnt_inc;
  logic [7:0] wsum, rsum, n_cmd;
  assign src_rd  = state == PROG && w_data_req;
  assign is_poll = state == POLL1 || state == POLL2;
  assign in_cmd  = state inside {WREN1, ERASE, POLL1, WREN2, PROG, POLL2, READ};
  assign wip     = spi_rvalid ? spi_rdata[0] : wip_q;
  assign cnt_inc = {1'b0, cnt} + 17'd1;
  assign again   = wip && cnt_inc < {1'b0, POLL_MAX};
  assign timeout = wip && !again;
  // pend marks the entry cycle; completions are only honoured once the launch is out
  assign adv = state == IDLE ? op_start : (state == CHECK || state == FIN) ? 1'b1 : in_cmd && spi_done && !pend;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = WREN1;
      WREN1:   nxt = ERASE;
      ERASE:   nxt = POLL1;
      POLL1:   nxt = again ? POLL1 : (timeout || len_q == '0) ? FIN : WREN2;
      WREN2:   nxt = PROG;
      PROG:    nxt = POLL2;
      POLL2:   nxt = again ? POLL2 : (timeout || !VERIFY_EN) ? FIN : READ;
      READ:    nxt = CHECK;
      CHECK:   nxt = FIN;
      default: nxt = IDLE;
    endcase
  end
  assign n_cmd = (nxt == WREN1 || nxt == WREN2) ? 8'h06 :
                 nxt == ERASE ? (ERASE_MODE ? 8'hC7 : 8'hD8) :
                 (nxt == POLL1 || nxt == POLL2) ? 8'h05 :
                 nxt == PROG ? 8'h02 : nxt == READ ? 8'h03 : 8'h00;
  assign n_addr = (nxt == PROG || nxt == READ || (nxt == ERASE && !ERASE_MODE)) ? addr_q : '0;
  assign n_len  = (nxt == PROG || nxt == READ) ? len_q : (nxt == POLL1 || nxt == POLL2) ? LEN_W'(1) : '0;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      pend      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 2'd0;
      spi_start <= 1'b0;
      spi_cmd   <= 8'h00;
      spi_addr  <= '0;
      spi_len   <= '0;
      spi_wdata <= 8'h00;
      addr_q    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      wip_q     <= 1'b0;
      wsum      <= 8'h00;
      rsum      <= 8'h00;
    end else begin
      spi_start <= pend;
      pend      <= 1'b0;
      done      <= 1'b0;
      if (src_rd) begin
        spi_wdata <= src_data;
        wsum      <= wsum + src_data;
      end
      if (state == READ && spi_rvalid) rsum <= rsum + spi_rdata;
      if (is_poll && spi_rvalid) wip_q <= spi_rdata[0];
      if (adv) begin
        state    <= nxt;
        pend     <= nxt inside {WREN1, ERASE, POLL1, WREN2, PROG, POLL2, READ};
        spi_cmd  <= n_cmd;
        spi_addr <= n_addr;
        spi_len  <= n_len;
        cnt      <= (is_poll && again) ? cnt_inc[15:0] : '0;
        if (nxt == FIN) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        if (is_poll && timeout) err <= 2'd1;
        if (state == CHECK) err <= rsum != wsum ? 2'd2 : 2'd0;
        if (state == IDLE) begin
          busy   <= 1'b1;
          addr_q <= op_addr;
          len_q  <= op_len;
          err    <= 2'd0;
          wsum   <= 8'h00;
          rsum   <= 8'h00;
        end
      end
    end
  end
endmodule

// File: tb/tb_flash_prog_seq.sv
// tb_flash_prog_seq: bench with an SPI engine responder and a transaction-level
// model of the expected command stream, error code and written bytes.
module tb_flash_prog_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic op_start = 1'b0;
  logic [23:0] op_addr = '0;
  logic [8:0] op_len = '0;
  logic spi_done = 1'b0, w_data_req = 1'b0, spi_rvalid = 1'b0;
  logic [7:0] src_data = '0, spi_rdata = '0;
  logic [1:0] sel = 2'd0;
  logic busy_d[3], done_d[3], start_d[3], rd_d[3];
  logic [1:0] err_d[3];
  logic [7:0] cmd_d[3], wdata_d[3];
  logic [23:0] addr_d[3];
  logic [8:0] len_d[3];
  wire busy = busy_d[sel];
  wire done = done_d[sel];
  wire spi_start = start_d[sel];
  wire src_rd = rd_d[sel];
  wire [1:0] err = err_d[sel];
  wire [7:0] spi_cmd = cmd_d[sel];
  wire [7:0] spi_wdata = wdata_d[sel];
  wire [23:0] spi_addr = addr_d[sel];
  wire [8:0] spi_len = len_d[sel];

  flash_prog_seq u0 (.sys_clk(clk), .sys_rst_n(rst_n), .op_start(op_start && sel == 2'd0), .op_addr(op_addr),
    .op_len(op_len), .busy(busy_d[0]), .done(done_d[0]), .err(err_d[0]), .spi_start(start_d[0]), .spi_cmd(cmd_d[0]),
    .spi_addr(addr_d[0]), .spi_len(len_d[0]), .spi_done(spi_done), .w_data_req(w_data_req), .src_data(src_data),
    .src_rd(rd_d[0]), .spi_wdata(wdata_d[0]), .spi_rdata(spi_rdata), .spi_rvalid(spi_rvalid));
  flash_prog_seq #(.ERASE_MODE(1'b1)) u1 (.sys_clk(clk), .sys_rst_n(rst_n), .op_start(op_start && sel == 2'd1),
    .op_addr(op_addr), .op_len(op_len), .busy(busy_d[1]), .done(done_d[1]), .err(err_d[1]), .spi_start(start_d[1]),
    .spi_cmd(cmd_d[1]), .spi_addr(addr_d[1]), .spi_len(len_d[1]), .spi_done(spi_done), .w_data_req(w_data_req),
    .src_data(src_data), .src_rd(rd_d[1]), .spi_wdata(wdata_d[1]), .spi_rdata(spi_rdata), .spi_rvalid(spi_rvalid));
  flash_prog_seq #(.POLL_MAX(16'd4)) u2 (.sys_clk(clk), .sys_rst_n(rst_n), .op_start(op_start && sel == 2'd2),
    .op_addr(op_addr), .op_len(op_len), .busy(busy_d[2]), .done(done_d[2]), .err(err_d[2]), .spi_start(start_d[2]),
    .spi_cmd(cmd_d[2]), .spi_addr(addr_d[2]), .spi_len(len_d[2]), .spi_done(spi_done), .w_data_req(w_data_req),
    .src_data(src_data), .src_rd(rd_d[2]), .spi_wdata(wdata_d[2]), .spi_rdata(spi_rdata), .spi_rvalid(spi_rvalid));

  int nchk = 0, nerr = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [23:0] addr;
    logic [8:0] len;
    bit use_addr;
  } cmd_t;
  cmd_t expq[$];
  bit wipq[$];
  logic [1:0] exp_err = 2'd0;
  logic [7:0] src_mem[16], rb_mem[16];
  logic [7:0] clog[$], wlog[$];
  logic [23:0] alog[$];
  int rd_cnt = 0, src_base = 0, done_cnt = 0;
  logic [7:0] l_full[7] = '{8'h06, 8'hD8, 8'h05, 8'h06, 8'h02, 8'h05, 8'h03};
  logic [7:0] l_wr[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] l_tmo[6] = '{8'h06, 8'hD8, 8'h05, 8'h05, 8'h05, 8'h05};
  logic [7:0] l_chip[3] = '{8'h06, 8'hC7, 8'h05};

  function automatic cmd_t mk(input logic [7:0] c, input logic [23:0] a, input logic [8:0] n, input bit u);
    cmd_t r;
    r.cmd = c;
    r.addr = a;
    r.len = n;
    r.use_addr = u;
    return r;
  endfunction

  // Expected transaction: command list and final error code from the flash protocol rules
  task automatic build(input bit em, input int pm, input logic [23:0] a, input logic [8:0] n, input int p1, input int p2);
    logic [7:0] ws = 8'h00, rs = 8'h00;
    expq.push_back(mk(8'h06, 24'h0, 9'd0, 1'b0));
    expq.push_back(em ? mk(8'hC7, 24'h0, 9'd0, 1'b1) : mk(8'hD8, a, 9'd0, 1'b1));
    for (int i = 0; i < (p1 < pm ? p1 + 1 : pm); i++) expq.push_back(mk(8'h05, 24'h0, 9'd1, 1'b0));
    if (p1 >= pm) begin exp_err = 2'd1; return; end
    if (n == 9'd0) begin exp_err = 2'd0; return; end
    expq.push_back(mk(8'h06, 24'h0, 9'd0, 1'b0));
    expq.push_back(mk(8'h02, a, n, 1'b1));
    for (int i = 0; i < (p2 < pm ? p2 + 1 : pm); i++) expq.push_back(mk(8'h05, 24'h0, 9'd1, 1'b0));
    if (p2 >= pm) begin exp_err = 2'd1; return; end
    expq.push_back(mk(8'h03, a, n, 1'b1));
    for (int i = 0; i < int'(n); i++) begin
      ws += src_mem[i];
      rs += rb_mem[i];
    end
    exp_err = ws == rs ? 2'd0 : 2'd2;
  endtask

  // SPI engine responder: gap cycle, data phase, then a done pulse
  int e_phase = 0, e_i = 0;
  logic [7:0] e_cmd = '0;
  logic [8:0] e_len = '0;
  bit eng_busy = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    spi_done = 1'b0;
    spi_rvalid = 1'b0;
    w_data_req = 1'b0;
    src_data = src_mem[4'(rd_cnt - src_base)];
    if (!rst_n) begin
      e_phase = 0;
      eng_busy = 1'b0;
    end else if (e_phase == 0) begin
      eng_busy = 1'b0;
      if (spi_start) begin
        e_cmd = spi_cmd;
        e_len = spi_len;
        e_i = 0;
        e_phase = 1;
        eng_busy = 1'b1;
      end
    end else if (e_phase == 1) e_phase = 2;
    else if (e_phase == 2) begin
      if (e_cmd == 8'h05) begin
        spi_rvalid = 1'b1;
        spi_rdata = 8'h00;
        if (wipq.size() > 0) spi_rdata[0] = wipq.pop_front();
        e_phase = 3;
      end else if ((e_cmd == 8'h02 || e_cmd == 8'h03) && e_i < int'(e_len)) begin
        if (e_cmd == 8'h02) w_data_req = 1'b1;
        else begin
          spi_rvalid = 1'b1;
          spi_rdata = rb_mem[e_i];
        end
        e_i++;
      end else e_phase = 3;
    end else begin
      spi_done = 1'b1;
      e_phase = 0;
    end
  end

  // Per-cycle compare against the model
  bit act = 1'b0, wpend = 1'b0;
  logic [7:0] exp_w = '0, cur_cmd = '0;
  initial forever begin
    cmd_t e;
    @(negedge clk);
    if (!rst_n) begin
      act = 1'b0;
      wpend = 1'b0;
    end else begin
      if (wpend) begin
        chk("spi_wdata", spi_wdata, exp_w);
        wlog.push_back(spi_wdata);
        wpend = 1'b0;
      end
      if (src_rd || w_data_req) chk("src_rd", src_rd, w_data_req && eng_busy && e_cmd == 8'h02);
      if (src_rd) begin
        exp_w = src_data;
        wpend = 1'b1;
        rd_cnt++;
      end
      if (spi_start) begin
        if (expq.size() == 0) chk("unexpected_cmd", spi_cmd, 8'h00);
        else begin
          e = expq.pop_front();
          chk("spi_cmd", spi_cmd, e.cmd);
          chk("spi_len", spi_len, e.len);
          if (e.use_addr) chk("spi_addr", spi_addr, e.addr);
        end
        clog.push_back(spi_cmd);
        alog.push_back(spi_addr);
        cur_cmd = spi_cmd;
      end else if (eng_busy) chk("spi_cmd_held", spi_cmd, cur_cmd);
      if (done) begin
        chk("done_while_active", act, 1);
        chk("err_at_done", err, exp_err);
        chk("busy_at_done", busy, 0);
        done_cnt++;
        act = 1'b0;
      end else chk("busy", busy, act);
      if (op_start && !act && !busy) act = 1'b1;
    end
  end

  task automatic start(input logic [1:0] s, input logic [23:0] a, input logic [8:0] n, input int p1, input int p2,
                       input bit em, input int pm, input bit extra);
    sel = s;
    src_base = rd_cnt;
    expq.delete();
    wipq.delete();
    clog.delete();
    alog.delete();
    wlog.delete();
    done_cnt = 0;
    for (int i = 0; i < p1; i++) wipq.push_back(1'b1);
    wipq.push_back(1'b0);
    for (int i = 0; i < p2; i++) wipq.push_back(1'b1);
    wipq.push_back(1'b0);
    build(em, pm, a, n, p1, p2);
    @(posedge clk); #1;
    op_addr = a;
    op_len = n;
    op_start = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
    if (extra) begin
      repeat (6) @(posedge clk);
      #1;
      op_addr = 24'hABCDEF;
      op_len = 9'd3;
      op_start = 1'b1;
      @(posedge clk); #1;
      op_start = 1'b0;
    end
  endtask

  task automatic finish_op();
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("done_count", done_cnt, 1);
    chk("cmds_remaining", expq.size(), 0);
    chk("busy_after", busy, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_spi_start"}, spi_start, 0);
    chk({tag, "_spi_cmd"}, spi_cmd, 0);
    chk({tag, "_spi_addr"}, spi_addr, 0);
    chk({tag, "_spi_len"}, spi_len, 0);
    chk({tag, "_src_rd"}, src_rd, 0);
    chk({tag, "_spi_wdata"}, spi_wdata, 0);
  endtask

  task automatic chk_full_literals();
    chk("cmd_count", clog.size(), 7);
    for (int i = 0; i < 7; i++) chk($sformatf("cmd_order[%0d]", i), clog[i], l_full[i]);
    chk("erase_addr", alog[1], 24'h012300);
    chk("pp_addr", alog[4], 24'h012300);
    chk("wdata_count", wlog.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("wdata[%0d]", i), wlog[i], l_wr[i]);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      src_mem[i] = 8'h00;
      rb_mem[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    src_mem[0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
    rb_mem[0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
    // Full sequence, matching read-back
    start(2'd0, 24'h012300, 9'd4, 0, 0, 1'b0, 50000, 1'b0);
    finish_op();
    chk_full_literals();
    chk("full_err", err, 2'd0);
    // Verify mismatch
    rb_mem[3] = 8'h45;
    start(2'd0, 24'h012300, 9'd4, 0, 0, 1'b0, 50000, 1'b0);
    finish_op();
    chk("verify_err", err, 2'd2);
    rb_mem[3] = 8'h44;
    // Poll timeout with POLL_MAX 4
    start(2'd2, 24'h012300, 9'd4, 6, 0, 1'b0, 4, 1'b0);
    finish_op();
    chk("tmo_cmd_count", clog.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("tmo_cmd[%0d]", i), clog[i], l_tmo[i]);
    chk("tmo_err", err, 2'd1);
    // Busy polling at the POLL_MAX boundary in both poll phases
    start(2'd2, 24'h000100, 9'd2, 3, 3, 1'b0, 4, 1'b0);
    finish_op();
    chk("poll_cmd_count", clog.size(), 13);
    for (int i = 2; i < 6; i++) chk($sformatf("poll1_rdsr[%0d]", i), clog[i], 8'h05);
    chk("poll1_then_wren", clog[6], 8'h06);
    chk("poll_err", err, 2'd0);
    // Chip erase, zero length
    start(2'd1, 24'h00ABCD, 9'd0, 0, 0, 1'b1, 50000, 1'b0);
    finish_op();
    chk("chip_cmd_count", clog.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("chip_cmd[%0d]", i), clog[i], l_chip[i]);
    chk("chip_addr", alog[1], 24'h0);
    chk("chip_src_rd", rd_cnt - src_base, 0);
    chk("chip_err", err, 2'd0);
    // Reset in the middle of PROG, then a fresh run with a stray op_start while busy
    start(2'd0, 24'h012300, 9'd4, 0, 0, 1'b0, 50000, 1'b0);
    for (int i = 0; i < 3000 && wlog.size() < 2; i++) @(posedge clk);
    chk("prog_bytes_before_reset", wlog.size() >= 2, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    start(2'd0, 24'h012300, 9'd4, 0, 0, 1'b0, 50000, 1'b1);
    finish_op();
    chk_full_literals();
    chk("rerun_err", err, 2'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
    $fatal(1);
  end
endmodule
